// File: rtl/cnt_sched_ctrl_pkg.sv
// Package cnt_sched_pkg
//   Shared definitions for the counter run-control sequencer.
//   - DEF_CNT_W / DEF_REP_W : default counter and repeat widths
//   - state_t               : FSM state encoding, also driven out on the state port
package cnt_sched_pkg;

  localparam int DEF_CNT_W = 10;
  localparam int DEF_REP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/cnt_sched_ctrl_if.sv
// Interface cnt_sched_ctrl_if
//   Config handshake and run-control signals between the control source
//   (master) and the sequencer (slave).
//   cfg_valid/cfg_ready : config write handshake
//   cfg_period          : period P, count runs 0..P-1 (P=0 invalid)
//   cfg_repeat          : wraps per run, 0 = infinite
//   start/pause/stop    : run-control levels sampled at each clock edge
interface cnt_sched_ctrl_if
  import cnt_sched_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int REP_W = DEF_REP_W
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_period;
  logic [REP_W-1:0] cfg_repeat;
  logic             start;
  logic             pause;
  logic             stop;

  modport master (
    output cfg_valid, cfg_period, cfg_repeat, start, pause, stop,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_repeat, start, pause, stop,
    output cfg_ready
  );
endinterface

// File: rtl/cnt_sched_ctrl_core.sv
// Module cnt_core
//   CNT_W time-base counter with synchronous clear and enable.
//   sclk, rst_n : clock, asynchronous active-low reset
//   clr         : force count to 0 (dominates en)
//   en          : advance one step this edge
//   period      : P; count runs 0..P-1 and wraps to 0
//   cnt         : current count
//   wrap        : cnt==P-1 while enabled, i.e. this edge wraps
module cnt_core #(
  parameter int CNT_W = 10
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_reg;

  assign wrap = en && (cnt_reg == period - CNT_W'(1));
  assign cnt  = cnt_reg;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= wrap ? '0 : cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cnt_sched_ctrl.sv
// Module cnt_sched_ctrl
//   Run-control sequencer for a free-running time-base counter: programmable
//   period, one-shot / N-repeat / infinite runs, pause and stop.
//   sclk, rst_n : clock, asynchronous active-low reset
//   ctl         : config handshake + start/pause/stop (slave side)
//   cnt         : current count value
//   tick        : 1-cycle pulse after each wrap P-1 -> 0
//   done        : 1-cycle pulse when the final wrap of a run is reached
//   busy        : high in RUN or PAUSE
//   state       : IDLE=0, RUN=1, PAUSE=2, DONE=3
module cnt_sched_ctrl
  import cnt_sched_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int REP_W = DEF_REP_W
) (
  input  logic             sclk,
  input  logic             rst_n,
  cnt_sched_ctrl_if.slave  ctl,
  output logic [CNT_W-1:0] cnt,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic [REP_W-1:0] repeat_reg, repeat_next;
  logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
  logic             tick_reg, tick_next;
  logic             done_reg, done_next;
  logic             busy_reg, busy_next;
  logic             ready_reg, ready_next;

  logic             accept;
  logic [CNT_W-1:0] eff_period;
  logic [REP_W:0]   rep_inc;
  logic             running;
  logic             core_clr, core_en, core_wrap;
  logic [CNT_W-1:0] core_cnt;

  assign accept  = ctl.cfg_valid && ready_reg;
  // A config accepted in the same IDLE cycle as start is used by that run.
  assign eff_period = accept ? ctl.cfg_period : period_reg;
  // Extra MSB flags the saturation point of rep_cnt.
  assign rep_inc = {1'b0, rep_cnt_reg} + (REP_W+1)'(1);
  assign running = (state_reg == ST_RUN) || (state_reg == ST_PAUSE);

  // Counter controls are decoded outside the FSM block so the wrap feedback
  // does not form a combinational loop through it. Stop beats pause beats
  // increment; a wrap held off by pause happens on the first un-paused edge.
  assign core_en  = running && !ctl.stop && !ctl.pause;
  assign core_clr = (running && ctl.stop) ||
                    ((state_reg == ST_IDLE) && ctl.start && (eff_period != '0));

  cnt_core #(.CNT_W(CNT_W)) u_core (
    .sclk   (sclk),
    .rst_n  (rst_n),
    .clr    (core_clr),
    .en     (core_en),
    .period (period_reg),
    .cnt    (core_cnt),
    .wrap   (core_wrap)
  );

  always_comb begin
    state_next   = state_reg;
    period_next  = period_reg;
    repeat_next  = repeat_reg;
    rep_cnt_next = rep_cnt_reg;
    tick_next    = 1'b0;
    done_next    = 1'b0;

    if (accept) begin
      period_next = ctl.cfg_period;
      repeat_next = ctl.cfg_repeat;
    end

    case (state_reg)
      ST_IDLE: begin
        if (ctl.start && (eff_period != '0)) begin
          state_next   = ST_RUN;
          rep_cnt_next = '0;
        end
      end
      ST_RUN, ST_PAUSE: begin
        if (ctl.stop) begin
          state_next = ST_IDLE;
        end else if (ctl.pause) begin
          state_next = ST_PAUSE;
        end else begin
          state_next = ST_RUN;
          if (core_wrap) begin
            tick_next = 1'b1;
            if (!rep_inc[REP_W]) begin
              rep_cnt_next = rep_inc[REP_W-1:0];
            end
            if ((repeat_reg != '0) && (rep_inc == {1'b0, repeat_reg})) begin
              state_next = ST_DONE;
              done_next  = 1'b1;
            end
          end
        end
      end
      // The final wrap already cleared the counter.
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    busy_next  = (state_next == ST_RUN)  || (state_next == ST_PAUSE);
    ready_next = (state_next == ST_IDLE) || (state_next == ST_DONE);
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      period_reg  <= '0;
      repeat_reg  <= '0;
      rep_cnt_reg <= '0;
      tick_reg    <= 1'b0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      ready_reg   <= 1'b1;
    end else begin
      state_reg   <= state_next;
      period_reg  <= period_next;
      repeat_reg  <= repeat_next;
      rep_cnt_reg <= rep_cnt_next;
      tick_reg    <= tick_next;
      done_reg    <= done_next;
      busy_reg    <= busy_next;
      ready_reg   <= ready_next;
    end
  end

  assign ctl.cfg_ready = ready_reg;
  assign cnt   = core_cnt;
  assign tick  = tick_reg;
  assign done  = done_reg;
  assign busy  = busy_reg;
  assign state = state_reg;

endmodule

// File: tb/tb_cnt_sched_ctrl.sv
// Testbench tb_cnt_sched_ctrl
//   Drives cnt_sched_ctrl at each falling edge, advances a behavioural model
//   of the run rules, and queues the expected outputs; a separate monitor
//   pops and compares one entry after every rising edge.
module tb_cnt_sched_ctrl;

  logic       sclk;
  logic       rst_n;
  logic [9:0] cnt;
  logic       tick, done, busy;
  logic [1:0] state;

  cnt_sched_ctrl_if #(.CNT_W(10), .REP_W(8)) ctl ();

  cnt_sched_ctrl #(.CNT_W(10), .REP_W(8)) dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .ctl   (ctl),
    .cnt   (cnt),
    .tick  (tick),
    .done  (done),
    .busy  (busy),
    .state (state)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  typedef struct packed {
    logic [1:0] st;
    logic       busy;
    logic       rdy;
    logic       tick;
    logic       done;
    logic [9:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle_no = 0;

  // Reference model: run status, position within the period, wraps so far.
  int m_st, m_cnt, m_rep, m_per, m_rpt;
  bit m_tick, m_done;

  function automatic void model_reset();
    m_st = 0; m_cnt = 0; m_rep = 0; m_per = 0; m_rpt = 0;
    m_tick = 0; m_done = 0;
  endfunction

  function automatic void model_step(bit v, int per, int rpt, bit st, bit pa, bit sp);
    bit ready;
    ready  = (m_st == 0) || (m_st == 3);
    m_tick = 0;
    m_done = 0;
    if (v && ready) begin
      m_per = per;
      m_rpt = rpt;
    end
    if (m_st == 0) begin
      if (st && m_per != 0) begin
        m_st = 1; m_cnt = 0; m_rep = 0;
      end
    end else if (m_st == 3) begin
      m_st = 0;
    end else if (sp) begin
      m_st = 0; m_cnt = 0;
    end else if (pa) begin
      m_st = 2;
    end else begin
      m_st  = 1;
      m_cnt = m_cnt + 1;
      if (m_cnt == m_per) begin
        m_cnt  = 0;
        m_tick = 1;
        if (m_rep < 255) m_rep = m_rep + 1;
        if (m_rpt != 0 && m_rep == m_rpt) begin
          m_st = 3;
          m_done = 1;
        end
      end
    end
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.st   = 2'(m_st);
    e.busy = (m_st == 1) || (m_st == 2);
    e.rdy  = (m_st == 0) || (m_st == 3);
    e.tick = m_tick;
    e.done = m_done;
    e.cnt  = 10'(m_cnt);
    exp_q.push_back(e);
  endfunction

  // Monitor: one comparison per rising edge that has a queued expectation.
  initial begin
    exp_t e, got;
    forever begin
      @(posedge sclk);
      #1;
      cycle_no++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {state, busy, ctl.cfg_ready, tick, done, cnt};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL cyc%0d outputs: got st=%0d busy=%0b rdy=%0b tick=%0b done=%0b cnt=%0d, exp st=%0d busy=%0b rdy=%0b tick=%0b done=%0b cnt=%0d",
                   cycle_no, got.st, got.busy, got.rdy, got.tick, got.done, got.cnt,
                   e.st, e.busy, e.rdy, e.tick, e.done, e.cnt);
        end
      end
    end
  end

  task automatic cyc(bit rstn, bit v, int per, int rpt, bit st, bit pa, bit sp);
    @(negedge sclk);
    rst_n          = rstn;
    ctl.cfg_valid  = v;
    ctl.cfg_period = per[9:0];
    ctl.cfg_repeat = rpt[7:0];
    ctl.start      = st;
    ctl.pause      = pa;
    ctl.stop       = sp;
    if (!rstn) model_reset();
    else model_step(v, per, rpt, st, pa, sp);
    push_exp();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_until_cnt(int c);
    for (int i = 0; i < 64; i++) begin
      if (m_st == 1 && m_cnt == c) break;
      cyc(1, 0, 0, 0, 0, 0, 0);
    end
  endtask

  // Drop rst_n between edges and check the outputs clear immediately.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({state, busy, ctl.cfg_ready, tick, done, cnt} !== {2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0}) begin
      errors++;
      $display("FAIL async_reset: got st=%0d busy=%0b rdy=%0b tick=%0b done=%0b cnt=%0d, exp st=0 busy=0 rdy=1 tick=0 done=0 cnt=0",
               state, busy, ctl.cfg_ready, tick, done, cnt);
    end
    exp_q.delete();
    model_reset();
    push_exp();
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int r, per;
    rst_n = 1'b0;
    ctl.cfg_valid = 0; ctl.cfg_period = '0; ctl.cfg_repeat = '0;
    ctl.start = 0; ctl.pause = 0; ctl.stop = 0;
    model_reset();
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // P=4 R=2 loaded with start in the same cycle: two periods then DONE.
    cyc(1, 1, 4, 2, 1, 0, 0);
    idle(11);

    // P=0 start is ignored.
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    idle(5);

    // P=5 infinite, pause 3 cycles at cnt=2.
    cyc(1, 1, 5, 0, 1, 0, 0);
    run_until_cnt(2);
    repeat (3) cyc(1, 0, 0, 0, 0, 1, 0);
    idle(20);
    cyc(1, 0, 0, 0, 0, 0, 1);
    idle(2);

    // P=4 infinite, pause exactly at cnt=3 defers the wrap.
    cyc(1, 1, 4, 0, 1, 0, 0);
    run_until_cnt(3);
    repeat (2) cyc(1, 0, 0, 0, 0, 1, 0);
    idle(6);
    cyc(1, 0, 0, 0, 1, 0, 1);
    idle(2);

    // P=8 R=3, stop at cnt=5 in the second period.
    cyc(1, 1, 8, 3, 1, 0, 0);
    for (int i = 0; i < 40; i++) begin
      if (m_rep == 1 && m_cnt == 5) break;
      cyc(1, 0, 0, 0, 0, 0, 0);
    end
    cyc(1, 0, 0, 0, 0, 0, 1);
    idle(4);

    // P=6 R=1, reset mid-run at cnt=4; start afterwards sees P=0.
    cyc(1, 1, 6, 1, 1, 0, 0);
    run_until_cnt(4);
    async_reset();
    cyc(1, 0, 0, 0, 1, 0, 0);
    idle(4);

    // P=1 ticks every cycle; max period runs one full wrap.
    cyc(1, 1, 1, 0, 1, 0, 0);
    idle(10);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 1023, 1, 1, 0, 0);
    idle(1030);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom % 16;
      per = (r < 12) ? (r % 8) : (r < 15) ? int'($urandom % 32) : 1023;
      cyc(1, ($urandom % 4) == 0, per, $urandom % 4, ($urandom % 3) == 0,
          ($urandom % 6) == 0, ($urandom % 40) == 0);
      if (($urandom % 400) == 0) async_reset();
    end

    idle(3);
    @(negedge sclk);
    @(negedge sclk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, exp 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
